dot_product_acc: RTL and testbench

- Sequential front/back stage wrapped around the 16x16 unsigned combinational multiplier.
- Accepts a burst of LEN operand pairs over a valid/ready stream and registers each pair onto the multiplier inputs.
- Captures each 32-bit product one cycle later and accumulates the products into an ACC_W-bit sum.
- Presents the final dot product on a valid/ready output with a sticky overflow flag.

---
 rtl/dot_product_acc_if.sv | 31 +++
 rtl/dot_product_acc.sv | 95 +++++++++
 tb/tb_dot_product_acc.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dot_product_acc_if.sv
// Stream, multiplier and result signals of dot_product_acc.
// master is the driving environment, slave is the accumulator.
interface dot_product_acc_if #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [15:0]      mul_a;
    logic [15:0]      mul_b;
    logic [31:0]      mul_p;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             overflow;
    logic             busy;

    modport master (
        output start, len, in_valid, in_a, in_b, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, out_sum, overflow, busy
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, mul_p, out_ready,
        output in_ready, mul_a, mul_b, out_valid, out_sum, overflow, busy
    );
endinterface

// File: rtl/dot_product_acc.sv
// Burst dot-product accumulator around an external 16x16 multiplier.
// Define DOT_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module dot_product_acc #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    dot_product_acc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] cnt;
    logic             v1;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [15:0]      ra;
    logic [15:0]      rb;
    logic             rdy;
    logic             xfer;
    logic             go;
    logic [ACC_W:0]   sum;

    assign xfer = bus.in_valid && rdy;
    assign go   = bus.start && (state == IDLE);
    assign sum  = {1'b0, acc} + (ACC_W+1)'(bus.mul_p);

    always_comb begin
        state_nx = state;
        rdy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_nx = (bus.len == '0) ? DONE : RUN;
            end
            RUN: begin
                rdy = 1'b1;
                if (xfer && cnt == LEN_W'(1))
                    state_nx = FLUSH;
            end
            FLUSH: state_nx = DONE;
            DONE: begin
                if (bus.out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra  <= '0;
            rb  <= '0;
            cnt <= '0;
            v1  <= 1'b0;
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            v1 <= xfer;
            if (xfer) begin
                ra  <= bus.in_a;
                rb  <= bus.in_b;
                cnt <= cnt - LEN_W'(1);
            end
            if (go) begin
                cnt <= bus.len;
                acc <= '0;
                ovf <= 1'b0;
            end else if (v1) begin
                ovf <= ovf | sum[ACC_W];
`ifdef DOT_ACC_SAT_EN
                // once carried, all-ones absorbs every later product
                acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                acc <= sum[ACC_W-1:0];
`endif
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.mul_a     = ra;
    assign bus.mul_b     = rb;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = acc;
    assign bus.overflow  = ovf;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench for dot_product_acc: ACC_W=40 and ACC_W=32 instances
// sharing clock and reset, each with a behavioural multiplier.
module tb_dot_product_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    dot_product_acc_if #(.ACC_W(40), .LEN_W(8)) b40 ();
    dot_product_acc_if #(.ACC_W(32), .LEN_W(8)) b32 ();

    assign b40.mul_p = b40.mul_a * b40.mul_b;
    assign b32.mul_p = b32.mul_a * b32.mul_b;

    dot_product_acc #(.ACC_W(40), .LEN_W(8)) dut40 (
        .clk(clk), .rst_n(rst_n), .bus(b40)
    );
    dot_product_acc #(.ACC_W(32), .LEN_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(b32)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] sa [4];
    logic [15:0] sb [4];
    logic [39:0] sum_max;
    logic [31:0] ovf_exp;
    logic [39:0] held;

    initial begin
        sa = '{16'd10, 16'd20, 16'd7, 16'd65535};
        sb = '{16'd10, 16'd5, 16'd7, 16'd1};
        sum_max = 40'd255 * 40'hFFFE0001;
`ifdef DOT_ACC_SAT_EN
        ovf_exp = 32'hFFFF_FFFF;
`else
        ovf_exp = 32'hFFFC_0002;
`endif
        b40.start = 0; b40.len = 0; b40.in_valid = 0;
        b40.in_a = 0; b40.in_b = 0; b40.out_ready = 0;
        b32.start = 0; b32.len = 0; b32.in_valid = 0;
        b32.in_a = 0; b32.in_b = 0; b32.out_ready = 0;

        // reset state
        tick; tick;
        chk("rst_busy", 64'(b40.busy), 64'd0);
        chk("rst_in_ready", 64'(b40.in_ready), 64'd0);
        chk("rst_out_valid", 64'(b40.out_valid), 64'd0);
        chk("rst_sum", 64'(b40.out_sum), 64'd0);
        chk("rst_mul_a", 64'(b40.mul_a), 64'd0);
        chk("rst_ovf", 64'(b40.overflow), 64'd0);
        rst_n = 1; tick;

        // basic burst
        b40.start = 1; b40.len = 3; tick;
        b40.start = 0;
        chk("basic_busy", 64'(b40.busy), 64'd1);
        chk("basic_rdy", 64'(b40.in_ready), 64'd1);
        b40.in_valid = 1; b40.in_a = 1; b40.in_b = 1; tick;
        b40.in_a = 2; b40.in_b = 2; tick;
        b40.in_a = 3; b40.in_b = 4; tick;
        b40.in_valid = 0;
        chk("basic_flush_ov", 64'(b40.out_valid), 64'd0);
        chk("basic_flush_rdy", 64'(b40.in_ready), 64'd0);
        chk("basic_mul_a", 64'(b40.mul_a), 64'd3);
        chk("basic_mul_b", 64'(b40.mul_b), 64'd4);
        tick;
        chk("basic_ov", 64'(b40.out_valid), 64'd1);
        chk("basic_sum", 64'(b40.out_sum), 64'd17);
        chk("basic_ovf", 64'(b40.overflow), 64'd0);
        b40.out_ready = 1; tick;
        b40.out_ready = 0;
        chk("basic_ov_drop", 64'(b40.out_valid), 64'd0);
        chk("basic_idle", 64'(b40.busy), 64'd0);

        // empty burst
        b40.start = 1; b40.len = 0; b40.in_valid = 1; tick;
        b40.start = 0;
        chk("empty_ov", 64'(b40.out_valid), 64'd1);
        chk("empty_sum", 64'(b40.out_sum), 64'd0);
        chk("empty_rdy", 64'(b40.in_ready), 64'd0);
        b40.out_ready = 1; tick;
        b40.out_ready = 0; b40.in_valid = 0;
        chk("empty_idle", 64'(b40.busy), 64'd0);

        // gapped input, stalled output
        b40.start = 1; b40.len = 4; tick;
        b40.start = 0;
        for (int i = 0; i < 4; i++) begin
            b40.in_valid = 1; b40.in_a = sa[i]; b40.in_b = sb[i]; tick;
            b40.in_valid = 0; b40.in_a = 16'hDEAD; b40.in_b = 16'hBEEF; tick;
        end
        chk("stall_ov", 64'(b40.out_valid), 64'd1);
        chk("stall_sum", 64'(b40.out_sum), 64'd65784);
        held = b40.out_sum;
        for (int i = 0; i < 5; i++) begin
            b40.start = (i == 2); b40.len = 2; tick;
            chk("stall_hold", 64'(b40.out_sum), 64'(held));
            chk("stall_hold_ov", 64'(b40.out_valid), 64'd1);
        end
        b40.start = 1; b40.out_ready = 1; tick;
        b40.start = 0; b40.out_ready = 0;
        chk("stall_start_ign", 64'(b40.busy), 64'd0);
        tick;
        chk("stall_still_idle", 64'(b40.busy), 64'd0);

        // overflow, 32-bit accumulator
        b32.start = 1; b32.len = 2; tick;
        b32.start = 0;
        b32.in_valid = 1; b32.in_a = 16'hFFFF; b32.in_b = 16'hFFFF; tick;
        tick;
        b32.in_valid = 0; tick;
        chk("ovf_ov", 64'(b32.out_valid), 64'd1);
        chk("ovf_sum", 64'(b32.out_sum), 64'(ovf_exp));
        chk("ovf_flag", 64'(b32.overflow), 64'd1);
        b32.out_ready = 1; tick;
        b32.out_ready = 0;
        b32.start = 1; b32.len = 0; tick;
        b32.start = 0;
        chk("ovf_cleared", 64'(b32.overflow), 64'd0);
        b32.out_ready = 1; tick;
        b32.out_ready = 0;

        // reset mid-burst
        b40.start = 1; b40.len = 5; tick;
        b40.start = 0;
        b40.in_valid = 1; b40.in_a = 7; b40.in_b = 9; tick;
        tick;
        b40.in_valid = 0;
        rst_n = 0; #1;
        chk("mrst_busy", 64'(b40.busy), 64'd0);
        chk("mrst_rdy", 64'(b40.in_ready), 64'd0);
        chk("mrst_ov", 64'(b40.out_valid), 64'd0);
        chk("mrst_sum", 64'(b40.out_sum), 64'd0);
        chk("mrst_mul_a", 64'(b40.mul_a), 64'd0);
        chk("mrst_mul_b", 64'(b40.mul_b), 64'd0);
        tick;
        rst_n = 1; tick;
        b40.start = 1; b40.len = 1; tick;
        b40.start = 0;
        b40.in_valid = 1; b40.in_a = 3; b40.in_b = 5; tick;
        b40.in_valid = 0; tick;
        chk("mrst_new_ov", 64'(b40.out_valid), 64'd1);
        chk("mrst_new_sum", 64'(b40.out_sum), 64'd15);
        b40.out_ready = 1; tick;
        b40.out_ready = 0;

        // max-length burst
        b40.start = 1; b40.len = 255; tick;
        b40.start = 0;
        b40.in_valid = 1; b40.in_a = 16'hFFFF; b40.in_b = 16'hFFFF;
        for (int i = 0; i < 255; i++) tick;
        b40.in_valid = 0;
        chk("max_flush_ov", 64'(b40.out_valid), 64'd0);
        tick;
        chk("max_ov", 64'(b40.out_valid), 64'd1);
        chk("max_sum", 64'(b40.out_sum), 64'(sum_max));
        chk("max_ovf", 64'(b40.overflow), 64'd0);
        b40.out_ready = 1; tick;
        b40.out_ready = 0;
        chk("max_idle", 64'(b40.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
